// File: rtl/shift_engine_pkg.sv
// shift_engine_pkg: mode encodings and FSM state codes shared by
// the shift engine and its single-step shifter.
package shift_engine_pkg;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_engine_step.sv
// shift_step: combinational one-bit shifter, returns the next word
// and the bit that leaves the word (for ROL, the bit wrapped to bit 0).
module shift_step
    import shift_engine_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] word,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_word,
    output logic             shifted_bit
);

    // Select the single-step shift for the current mode.
    always_comb begin
        next_word   = word;
        shifted_bit = 1'b0;
        case (mode)
            MODE_LSL: begin
                next_word   = {word[WIDTH-2:0], 1'b0};
                shifted_bit = word[WIDTH-1];
            end
            MODE_LSR: begin
                next_word   = {1'b0, word[WIDTH-1:1]};
                shifted_bit = word[0];
            end
            MODE_ASR: begin
                next_word   = {word[WIDTH-1], word[WIDTH-1:1]};
                shifted_bit = word[0];
            end
            MODE_ROL: begin
                next_word   = {word[WIDTH-2:0], word[WIDTH-1]};
                shifted_bit = word[WIDTH-1];
            end
            default: begin
                next_word   = word;
                shifted_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_engine.sv
// shift_engine: multi-cycle shifter, one bit per cycle, valid/ready on
// both sides. Define SHIFT_ENGINE_CARRY_EN to add the oCarry output.
module shift_engine
    import shift_engine_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iValid,
    output logic                     oReady,
    input  logic [WIDTH-1:0]         iData,
    input  logic [$clog2(WIDTH)-1:0] iAmt,
    input  logic [1:0]               iMode,
    output logic                     oValid,
    input  logic                     iReady,
    output logic [WIDTH-1:0]         oData,
`ifdef SHIFT_ENGINE_CARRY_EN
    output logic                     oCarry,
`endif
    output logic                     oBusy
);

    localparam int AMT_W = $clog2(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] work;
    logic [AMT_W-1:0] cnt;
    logic [1:0]       mode;
    logic             valid;
    logic [WIDTH-1:0] step_word;
    logic             step_bit;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .word       (work),
        .mode       (mode),
        .next_word  (step_word),
        .shifted_bit(step_bit)
    );

    // Control FSM and datapath; oValid rises one cycle after DONE is
    // entered so latency is amount+1 cycles, including amount 0.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= ST_IDLE;
            work  <= '0;
            cnt   <= '0;
            mode  <= MODE_LSL;
            valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iValid) begin
                        work  <= iData;
                        cnt   <= iAmt;
                        mode  <= iMode;
                        state <= (iAmt != '0) ? ST_SHIFT : ST_DONE;
                    end
                end
                ST_SHIFT: begin
                    work <= step_word;
                    cnt  <= cnt - 1'b1;
                    if (cnt == AMT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!valid) begin
                        valid <= 1'b1;
                    end else if (iReady) begin
                        valid <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHIFT_ENGINE_CARRY_EN
    logic carry;

    // Track the last bit shifted out; cleared at accept so amount 0 gives 0.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            carry <= 1'b0;
        end else if (state == ST_IDLE && iValid) begin
            carry <= 1'b0;
        end else if (state == ST_SHIFT) begin
            carry <= step_bit;
        end
    end

    assign oCarry = carry;
`else
    logic carry_unused;
    assign carry_unused = step_bit;
`endif

    assign oReady = (state == ST_IDLE);
    assign oBusy  = (state != ST_IDLE);
    assign oValid = valid;
    assign oData  = work;

endmodule

// File: tb/tb_shift_engine.sv
// tb_shift_engine: scoreboard bench for shift_engine, WIDTH=8.
// Checks oCarry too when SHIFT_ENGINE_CARRY_EN is defined.
module tb_shift_engine;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] data;
        logic         carry;
        int           amt;
        int           acc;
    } exp_t;

    logic         iClk;
    logic         iRst;
    logic         iValid;
    logic         oReady;
    logic [W-1:0] iData;
    logic [2:0]   iAmt;
    logic [1:0]   iMode;
    logic         oValid;
    logic         iReady;
    logic [W-1:0] oData;
    logic         oBusy;
`ifdef SHIFT_ENGINE_CARRY_EN
    logic         oCarry;
`endif

    int   n_checks;
    int   n_errors;
    int   cyc;
    bit   seen;
    bit   have_prev;
    int   prev_acc;
    int   prev_amt;
    exp_t sb[$];

    shift_engine #(
        .WIDTH(W)
    ) dut (
        .iClk  (iClk),
        .iRst  (iRst),
        .iValid(iValid),
        .oReady(oReady),
        .iData (iData),
        .iAmt  (iAmt),
        .iMode (iMode),
        .oValid(oValid),
        .iReady(iReady),
        .oData (oData),
`ifdef SHIFT_ENGINE_CARRY_EN
        .oCarry(oCarry),
`endif
        .oBusy (oBusy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(logic [W-1:0] d, int a, logic [1:0] m);
        exp_t e;
        e.amt   = a;
        e.acc   = 0;
        e.carry = 1'b0;
        e.data  = d;
        case (m)
            2'b00: begin
                e.data = d << a;
                if (a > 0) e.carry = d[W-a];
            end
            2'b01: begin
                e.data = d >> a;
                if (a > 0) e.carry = d[a-1];
            end
            2'b10: begin
                e.data = $signed(d) >>> a;
                if (a > 0) e.carry = d[a-1];
            end
            default: begin
                if (a > 0) begin
                    e.data  = (d << a) | (d >> (W - a));
                    e.carry = d[W-a];
                end
            end
        endcase
        return e;
    endfunction

    // Send one request: wait for oReady, hold iValid over one edge.
    task automatic send(logic [W-1:0] d, int a, logic [1:0] m);
        exp_t e;
        int   w;
        w = 0;
        while (!oReady && w < 200) begin
            @(posedge iClk);
            #1;
            w++;
        end
        if (!oReady) check("ready_timeout", 32'(oReady), 32'd1);
        iValid = 1'b1;
        iData  = d;
        iAmt   = 3'(a);
        iMode  = m;
        @(posedge iClk);
        #1;
        e     = model(d, a, m);
        e.acc = cyc;
        sb.push_back(e);
        if (have_prev)
            check("spacing", 32'(cyc - prev_acc >= prev_amt + 2), 32'd1);
        have_prev = 1'b1;
        prev_acc  = cyc;
        prev_amt  = a;
        iValid    = 1'b0;
        iData     = W'($urandom);
        iAmt      = 3'($urandom);
        iMode     = 2'($urandom);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(posedge iClk);
            #1;
            w++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard side: latency on first oValid, data on handoff.
    always @(negedge iClk) begin
        exp_t e;
        if (!iRst) begin
            if (oValid && !seen) begin
                seen = 1'b1;
                if (sb.size() == 0)
                    check("stale_valid", 32'd1, 32'd0);
                else
                    check("latency", 32'(cyc - sb[0].acc),
                          32'(sb[0].amt + 1));
            end
            if (oValid && iReady) begin
                seen = 1'b0;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("data", 32'(oData), 32'(e.data));
`ifdef SHIFT_ENGINE_CARRY_EN
                    check("carry", 32'(oCarry), 32'(e.carry));
`endif
                end
            end
        end
    end

    initial begin
        logic [W-1:0] held;
        int           w;
        int           nvalid;
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        seen      = 1'b0;
        have_prev = 1'b0;
        prev_acc  = 0;
        prev_amt  = 0;
        iRst      = 1'b1;
        iValid    = 1'b0;
        iData     = '0;
        iAmt      = '0;
        iMode     = '0;
        iReady    = 1'b1;

        repeat (3) @(posedge iClk);
        #1;
        check("rst_valid", 32'(oValid), 32'd0);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_ready", 32'(oReady), 32'd1);
        check("rst_data", 32'(oData), 32'd0);
        iRst = 1'b0;
        @(posedge iClk);
        #1;

        send(8'h96, 3, 2'b00);
        wait_drain();
        send(8'h96, 2, 2'b01);
        wait_drain();
        send(8'h96, 2, 2'b10);
        wait_drain();
        send(8'h96, 1, 2'b11);
        wait_drain();
        for (int m = 0; m < 4; m++) begin
            send(8'h5A, 0, 2'(m));
            wait_drain();
        end

        iReady = 1'b0;
        send(8'h3C, 2, 2'b00);
        w = 0;
        while (!oValid && w < 50) begin
            @(posedge iClk);
            #1;
            w++;
        end
        check("hold_valid", 32'(oValid), 32'd1);
        held = oData;
        for (int i = 0; i < 5; i++) begin
            iValid = ~iValid;
            iData  = W'($urandom);
            iAmt   = 3'($urandom);
            @(posedge iClk);
            #1;
            check("hold_data", 32'(oData), 32'(held));
            check("hold_ready", 32'(oReady), 32'd0);
        end
        iValid = 1'b0;
        iReady = 1'b1;
        @(posedge iClk);
        #1;
        check("handoff_ready", 32'(oReady), 32'd1);
        check("handoff_valid", 32'(oValid), 32'd0);
        wait_drain();

        send(8'hFF, 7, 2'b01);
        repeat (3) @(posedge iClk);
        #1;
        iRst = 1'b1;
        @(posedge iClk);
        #1;
        check("abort_valid", 32'(oValid), 32'd0);
        check("abort_data", 32'(oData), 32'd0);
        check("abort_ready", 32'(oReady), 32'd1);
        check("abort_busy", 32'(oBusy), 32'd0);
        iRst = 1'b0;
        sb.delete();
        seen      = 1'b0;
        have_prev = 1'b0;
        nvalid    = 0;
        repeat (12) begin
            @(posedge iClk);
            #1;
            if (oValid) nvalid++;
        end
        check("abort_no_stale", 32'(nvalid), 32'd0);

        for (int i = 0; i < 20; i++) begin
            send(W'($urandom), int'($urandom_range(0, W - 1)),
                 2'($urandom_range(0, 3)));
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_engine.md
SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width in bits; it is a power of two and at least 2.
REQ-002 The block SHALL have derived constant AMT_W = log2(WIDTH), meaning the shift-amount width; it is not user-overridable.
REQ-003 The block SHALL have port iClk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port iRst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port iValid, input, 1 bit: request valid.
REQ-006 The block SHALL have port oReady, output, 1 bit: the engine accepts a request this cycle.
REQ-007 The block SHALL have port iData, input, WIDTH bits: operand.
REQ-008 The block SHALL have port iAmt, input, AMT_W bits: shift distance, 0 to WIDTH-1.
REQ-009 The block SHALL have port iMode, input, 2 bits: 00 logical left (LSL), 01 logical right (LSR), 10 arithmetic right (ASR), 11 rotate left (ROL).
REQ-010 The block SHALL have port oValid, output, 1 bit: result valid.
REQ-011 The block SHALL have port iReady, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port oData, output, WIDTH bits: result.
REQ-013 The block SHALL have port oBusy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and DONE; oReady SHALL equal 1 only in IDLE.
REQ-015 In IDLE, iValid=1 (accept) SHALL capture iData, iAmt and iMode; next state SHIFT if iAmt!=0, else DONE.
REQ-016 Each SHIFT cycle SHALL move the working register exactly one bit per the captured mode and decrement the remaining count; the count reaching 0 SHALL move the FSM to DONE.
REQ-017 Per-step rules: LSL inserts 0 at bit 0; LSR inserts 0 at the MSB; ASR replicates the MSB; ROL moves the old MSB to bit 0.
REQ-018 Latency: with accept at edge T, oValid SHALL rise after edge T+N+1 for iAmt=N, including N=0 (T+1).
REQ-019 In DONE, oValid=1 and oData SHALL be held stable until iReady=1; the handoff edge SHALL return the FSM to IDLE.
REQ-020 No request SHALL be accepted in the handoff cycle; the earliest next accept is the following cycle.
REQ-021 iValid outside IDLE SHALL be ignored; inputs SHALL be sampled only at accept.
REQ-022 oData SHALL show the working register in all states; its content is meaningful only while oValid=1.

Reset
REQ-023 iRst=1 SHALL force, at the next edge: state IDLE, oValid 0, oBusy 0, oReady 1 (combinational from IDLE), oData 0 and count 0.
REQ-024 Reset SHALL take priority over every other event, aborting any in-flight SHIFT or DONE; the aborted result SHALL be discarded and never presented.

Configuration
REQ-025 Macro SHIFT_ENGINE_CARRY_EN SHALL control the carry feature; when it is defined, port oCarry (output, 1 bit) SHALL exist.
REQ-026 With SHIFT_ENGINE_CARRY_EN defined, oCarry SHALL hold the last bit shifted out (ROL: the bit wrapped into bit 0); it SHALL be 0 for N=0, reset to 0, and be valid with oValid.
REQ-027 With SHIFT_ENGINE_CARRY_EN undefined, the port and its register SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-028 Package shift_engine_pkg SHALL hold the mode encoding constants (LSL/LSR/ASR/ROL) and the FSM state enumeration.
REQ-029 Sub-module shift_step SHALL be combinational, with inputs word and mode and outputs the next word and the shifted-out bit; it SHALL be instantiated once.

Verification
REQ-030 Scenario SHALL cover, WIDTH=8: LSL 0x96 amt 3 accepted at T -> oValid after T+4, oData 0xB0, oCarry 0.
REQ-031 Scenario SHALL cover: LSR 0x96 amt 2 -> 0x25, oCarry 1; ASR 0x96 amt 2 -> 0xE5, oCarry 1; ROL 0x96 amt 1 -> 0x2D, oCarry 1.
REQ-032 Scenario SHALL cover: amt 0, any mode, 0x5A -> oValid after T+1, oData 0x5A, oCarry 0.
REQ-033 Scenario SHALL cover: iReady held low 5 cycles in DONE while iValid toggles -> oData stable, oReady 0, no accept; iReady=1 -> IDLE next cycle, oReady 1.
REQ-034 Scenario SHALL cover: iRst pulsed during SHIFT of an amt-7 request -> next cycle IDLE, oValid 0, oData 0; no stale oValid follows.
REQ-035 Scenario SHALL cover: back-to-back requests with iReady tied 1 -> each result correct; accepts at least N+2 cycles apart.
